// File: rtl/sccb_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : sccb_init_seq
// Description : Walks a register-initialisation table held in an external
//               combinational ROM. Each entry is issued as one SCCB write
//               through a request/ack/done handshake. Entries with register
//               address 0xFF are delay markers and wait data*TICK_CYCLES
//               cycles instead of issuing a write. Consecutive entries are
//               separated by GAP_CYCLES idle cycles.
//               Optional macro SCCB_INIT_READBACK_EN reads every written
//               register back and raises a sticky error on a mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_init_seq #(
  parameter int unsigned NUM_ENTRIES = 64,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned TICK_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  tbl_index,
  input  logic [15:0] tbl_entry,
  output logic        write_request,
  output logic [7:0]  write_addr,
  output logic [7:0]  write_data,
  input  logic        request_ack,
  input  logic        done,
  output logic        busy,
  output logic        init_done
`ifdef SCCB_INIT_READBACK_EN
  ,
  output logic        read_request,
  output logic [7:0]  read_addr,
  input  logic [7:0]  read_data,
  output logic        error
`endif
);

  // One shared down-counter serves both the delay marker and the gap, so it
  // must hold the larger of the longest delay (data=255) and the gap length.
  localparam int unsigned c_MAX_DELAY = 255 * TICK_CYCLES;
  localparam int unsigned c_MAX_CNT   = (c_MAX_DELAY > GAP_CYCLES) ? c_MAX_DELAY : GAP_CYCLES;
  localparam int          c_CNT_W     = $clog2(c_MAX_CNT + 1);

  localparam logic [c_CNT_W-1:0] c_GAP_LOAD = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TICK     = c_CNT_W'(TICK_CYCLES);
  localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
  localparam logic [7:0]         c_LAST_IDX = 8'(NUM_ENTRIES - 1);
  localparam logic [7:0]         c_DLY_ADDR = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT_DONE,
    S_DELAY,
    S_GAP,
    S_FINISHED
`ifdef SCCB_INIT_READBACK_EN
    ,
    S_RB_REQ,
    S_RB_WAIT
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           index_q, index_d;
  logic [7:0]           addr_q,  addr_d;
  logic [7:0]           data_q,  data_d;
  logic [c_CNT_W-1:0]   cnt_q,   cnt_d;
  logic                 wreq_q;
  logic [c_CNT_W-1:0]   w_delay_total;
`ifdef SCCB_INIT_READBACK_EN
  logic                 rreq_q;
  logic                 err_q,   err_d;
`endif

  // Delay length of the entry currently presented by the ROM.
  assign w_delay_total = c_CNT_W'(tbl_entry[7:0]) * c_TICK;

  // Next-state, table index, latched entry and shared counter.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef SCCB_INIT_READBACK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE, S_FINISHED: begin
        if (start) begin
          state_d = S_LOAD;
          index_d = '0;
          cnt_d   = '0;
`ifdef SCCB_INIT_READBACK_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        addr_d = tbl_entry[15:8];
        data_d = tbl_entry[7:0];
        if (tbl_entry[15:8] == c_DLY_ADDR) begin
          state_d = S_DELAY;
          // A zero delay still spends one cycle in DELAY.
          cnt_d   = (w_delay_total == '0) ? '0 : (w_delay_total - c_ONE);
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (request_ack) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (done) begin
`ifdef SCCB_INIT_READBACK_EN
          state_d = S_RB_REQ;
`else
          state_d = S_GAP;
          cnt_d   = c_GAP_LOAD;
`endif
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = c_GAP_LOAD;
        end else begin
          cnt_d   = cnt_q - c_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (index_q == c_LAST_IDX) begin
            state_d = S_FINISHED;
          end else begin
            state_d = S_LOAD;
            index_d = index_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q - c_ONE;
        end
      end
`ifdef SCCB_INIT_READBACK_EN
      S_RB_REQ: begin
        if (request_ack) begin
          state_d = S_RB_WAIT;
        end
      end
      S_RB_WAIT: begin
        if (done) begin
          if (read_data != data_q) begin
            err_d = 1'b1;
          end
          state_d = S_GAP;
          cnt_d   = c_GAP_LOAD;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; request strobes are registered so the
  // SCCB master sees glitch-free levels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      index_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      wreq_q  <= 1'b0;
`ifdef SCCB_INIT_READBACK_EN
      rreq_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wreq_q  <= (state_d == S_REQ);
`ifdef SCCB_INIT_READBACK_EN
      rreq_q  <= (state_d == S_RB_REQ);
      err_q   <= err_d;
`endif
    end
  end

  assign tbl_index     = index_q;
  assign write_request = wreq_q;
  assign write_addr    = addr_q;
  assign write_data    = data_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_FINISHED);
  assign init_done     = (state_q == S_FINISHED);
`ifdef SCCB_INIT_READBACK_EN
  assign read_request  = rreq_q;
  assign read_addr     = addr_q;
  assign error         = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sccb_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sccb_init_seq
// Description : Self-checking bench for sccb_init_seq. A three-entry ROM
//               {0x1280, 0xFF03, 0x22FF} exercises a write, a delay marker and
//               a final write. A small SCCB master model acks 3 cycles after a
//               request and reports done 50 cycles after the ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_init_seq;

  localparam int NUM_E    = 3;
  localparam int GAP      = 4;
  localparam int TICK     = 10;
  localparam int ACK_LAT  = 3;
  localparam int DONE_LAT = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  tbl_index;
  logic [15:0] tbl_entry;
  logic        write_request;
  logic [7:0]  write_addr;
  logic [7:0]  write_data;
  logic        request_ack;
  logic        done;
  logic        busy;
  logic        init_done;
`ifdef SCCB_INIT_READBACK_EN
  logic        read_request;
  logic [7:0]  read_addr;
  logic [7:0]  read_data;
  logic        error;
`endif

  // Bench controls
  logic auto_sccb  = 1'b0;
  logic early_done = 1'b0;
  int   ack_hold   = 1;
  logic corrupt    = 1'b0;
  logic t_ack      = 1'b0;
  logic t_done     = 1'b0;

  // SCCB model state
  logic m_ack  = 1'b0;
  logic m_done = 1'b0;
  int   m_phase = 0;
  int   m_cnt   = 0;
  int   last_done_cyc = 0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] rom [NUM_E];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign tbl_entry   = (tbl_index < 8'(NUM_E)) ? rom[tbl_index[1:0]] : 16'h0000;
  assign request_ack = auto_sccb ? m_ack : t_ack;
  assign done        = auto_sccb ? m_done : t_done;
`ifdef SCCB_INIT_READBACK_EN
  assign read_data   = (corrupt && write_data == 8'h80) ? 8'h7F : write_data;
`endif

  sccb_init_seq #(
    .NUM_ENTRIES (NUM_E),
    .GAP_CYCLES  (GAP),
    .TICK_CYCLES (TICK)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .tbl_index     (tbl_index),
    .tbl_entry     (tbl_entry),
    .write_request (write_request),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .request_ack   (request_ack),
    .done          (done),
    .busy          (busy),
    .init_done     (init_done)
`ifdef SCCB_INIT_READBACK_EN
    ,
    .read_request  (read_request),
    .read_addr     (read_addr),
    .read_data     (read_data),
    .error         (error)
`endif
  );

  logic w_req_any;
`ifdef SCCB_INIT_READBACK_EN
  assign w_req_any = write_request | read_request;
`else
  assign w_req_any = write_request;
`endif

  // SCCB master model, driven on the falling edge.
  always @(negedge clk) begin
    m_done = 1'b0;
    if (!rst || !auto_sccb) begin
      m_ack   = 1'b0;
      m_phase = 0;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        0: if (w_req_any) begin
             m_phase = 1;
             m_cnt   = 1;
             if (early_done) m_done = 1'b1;
           end
        1: if (m_cnt == ACK_LAT) begin
             m_ack   = 1'b1;
             m_cnt   = 1;
             m_phase = 2;
           end else begin
             m_cnt = m_cnt + 1;
           end
        default: begin
          if (m_cnt >= ack_hold) m_ack = 1'b0;
          if (m_cnt == DONE_LAT) begin
            m_done        = 1'b1;
            m_ack         = 1'b0;
            m_phase       = 0;
            last_done_cyc = cyc;
          end
          m_cnt = m_cnt + 1;
        end
      endcase
    end
  end

  // Transaction monitor
  int         wr_cnt = 0;
  logic [7:0] wr_addr_a [64];
  logic [7:0] wr_data_a [64];
  int         len_cnt = 0;
  int         len_a [64];
  int         run = 0;
  logic       wreq_prev = 1'b0;
  logic [7:0] idx_prev = 8'h00;
  int         idx_cyc [4];
  int         gap_idx1 = 0;
`ifdef SCCB_INIT_READBACK_EN
  int         rd_cnt = 0;
  logic [7:0] rd_addr_a [64];
  logic       rreq_prev = 1'b0;
`endif

  always @(negedge clk) begin
    if (write_request && !wreq_prev) begin
      wr_addr_a[wr_cnt % 64] = write_addr;
      wr_data_a[wr_cnt % 64] = write_data;
      wr_cnt = wr_cnt + 1;
    end
    wreq_prev = write_request;
`ifdef SCCB_INIT_READBACK_EN
    if (read_request && !rreq_prev) begin
      rd_addr_a[rd_cnt % 64] = read_addr;
      rd_cnt = rd_cnt + 1;
    end
    rreq_prev = read_request;
`endif
    if (w_req_any) begin
      run = run + 1;
    end else if (run != 0) begin
      len_a[len_cnt % 64] = run;
      len_cnt = len_cnt + 1;
      run = 0;
    end
    if (tbl_index != idx_prev) begin
      if (tbl_index < 8'd4) idx_cyc[tbl_index[1:0]] = cyc;
      if (tbl_index == 8'd1) gap_idx1 = cyc - last_done_cyc;
    end
    idx_prev = tbl_index;
  end

  typedef struct {
    logic       rst_n;
    logic       st;
    logic       ack;
    logic       dn;
    logic [7:0] idx;
    logic       wreq;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       bsy;
    logic       idone;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst   = 1'b0;
    tick();
    rst   = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_init(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (init_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit ok;
    int bw;
    int bl;

    rom[0] = 16'h1280;
    rom[1] = 16'hFF03;
    rom[2] = 16'h22FF;

    //           rst st ack dn  idx   wreq waddr  wdata  busy idone
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h12, 8'h80, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h12, 8'h80, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h12, 8'h80, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h12, 8'h80, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h12, 8'h80, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h12, 8'h80, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h12, 8'h80, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h12, 8'h80, 1'b1, 1'b0};

    // Cycle-by-cycle vectors with the handshake driven by hand.
    for (int i = 0; i < 11; i++) begin
      rst    = vecs[i].rst_n;
      start  = vecs[i].st;
      t_ack  = vecs[i].ack;
      t_done = vecs[i].dn;
      tick();
      check($sformatf("vec%0d", i),
            {6'd0, tbl_index, write_request, write_addr, write_data, busy, init_done},
            {6'd0, vecs[i].idx, vecs[i].wreq, vecs[i].waddr, vecs[i].wdata, vecs[i].bsy, vecs[i].idone});
    end
    t_ack  = 1'b0;
    t_done = 1'b0;
    auto_sccb = 1'b1;

    // Full walk: two writes around a 30-cycle delay marker.
    do_reset();
    bw = wr_cnt;
    bl = len_cnt;
    pulse_start();
    wait_init(3000, ok);
    check("walk_a_complete", 32'(ok), 32'd1);
    check("walk_a_writes", 32'(wr_cnt - bw), 32'd2);
    check("walk_a_w0", {16'd0, wr_addr_a[bw % 64], wr_data_a[bw % 64]}, 32'h1280);
    check("walk_a_w1", {16'd0, wr_addr_a[(bw + 1) % 64], wr_data_a[(bw + 1) % 64]}, 32'h22FF);
    check("walk_a_gap", 32'(gap_idx1), 32'(GAP + 1));
    check("walk_a_delay", 32'(idx_cyc[2] - idx_cyc[1]), 32'(1 + 3 * TICK + GAP));
    check("walk_a_reqlen", 32'(len_a[bl % 64]), 32'(ACK_LAT + 1));
    check("walk_a_end", {30'd0, busy, init_done}, 32'b01);
    tick();
    tick();
    check("walk_a_hold", {23'd0, tbl_index, init_done}, {23'd0, 8'd2, 1'b1});
`ifdef SCCB_INIT_READBACK_EN
    check("walk_a_noerr", 32'(error), 32'd0);
`endif

    // Done before ack and ack held for 5 cycles.
    do_reset();
    early_done = 1'b1;
    ack_hold   = 5;
    bw = wr_cnt;
    bl = len_cnt;
    pulse_start();
    wait_init(3000, ok);
    check("walk_b_complete", 32'(ok), 32'd1);
    check("walk_b_writes", 32'(wr_cnt - bw), 32'd2);
    check("walk_b_reqlen0", 32'(len_a[bl % 64]), 32'(ACK_LAT + 1));
    check("walk_b_reqlen1", 32'(len_a[(bl + 1) % 64]), 32'(ACK_LAT + 1));
    check("walk_b_w1", {16'd0, wr_addr_a[(bw + 1) % 64], wr_data_a[(bw + 1) % 64]}, 32'h22FF);
    early_done = 1'b0;
    ack_hold   = 1;

    // Reset while waiting for done of the last write, then restart.
    do_reset();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (tbl_index == 8'd2 && write_request) begin ok = 1'b1; break; end
      tick();
    end
    check("rst_reach_req", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!write_request) begin ok = 1'b1; break; end
      tick();
    end
    check("rst_reach_wait", 32'(ok), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_outputs", {6'd0, tbl_index, write_request, write_addr, write_data, busy, init_done}, 32'd0);
`ifdef SCCB_INIT_READBACK_EN
    check("rst_rb_outputs", {30'd0, read_request, error}, 32'd0);
`endif
    rst = 1'b1;
    tick();
    tick();
    check("rst_stays_idle", {30'd0, busy, write_request}, 32'd0);
    bw = wr_cnt;
    pulse_start();
    check("rst_restart", {23'd0, tbl_index, busy}, {23'd0, 8'd0, 1'b1});
    wait_init(3000, ok);
    check("rst_walk_complete", 32'(ok), 32'd1);
    check("rst_walk_w0", {16'd0, wr_addr_a[bw % 64], wr_data_a[bw % 64]}, 32'h1280);

    // Start held high: walks repeat with a single FINISHED cycle between.
    do_reset();
    bw = wr_cnt;
    start = 1'b1;
    wait_init(3000, ok);
    check("held_first_walk", 32'(ok), 32'd1);
    tick();
    check("held_rewalk", {22'd0, tbl_index, busy, init_done}, {22'd0, 8'd0, 1'b1, 1'b0});
    wait_init(3000, ok);
    check("held_second_walk", 32'(ok), 32'd1);
    check("held_writes", 32'(wr_cnt - bw), 32'd4);
    start = 1'b0;
    tick();
    tick();
    check("held_release", {30'd0, busy, init_done}, 32'b01);

`ifdef SCCB_INIT_READBACK_EN
    // Read-back mismatch on the first entry sets a sticky error.
    do_reset();
    corrupt = 1'b1;
    bw = rd_cnt;
    pulse_start();
    wait_init(3000, ok);
    check("rb_complete", 32'(ok), 32'd1);
    check("rb_reads", 32'(rd_cnt - bw), 32'd2);
    check("rb_addr0", 32'(rd_addr_a[bw % 64]), 32'h12);
    check("rb_error", 32'(error), 32'd1);
    tick();
    tick();
    check("rb_error_sticky", {30'd0, init_done, error}, 32'b11);
    pulse_start();
    check("rb_error_clear", {30'd0, busy, error}, 32'b10);
    corrupt = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
